ualink_dpmem_fifo_ctrl: RTL

Streaming FIFO controller that turns the external 256x64 dual-port RAM into a circular packet buffer. A valid/ready ingress stream is written through RAM port A. Port B is used read-only, with a 2-entry output skid buffer that absorbs the RAM's 1-cycle read latency and sustains 1 word/cycle under egress backpressure. It sits directly upstream of the dual-port RAM, between the ingress parser and the turbo64 egress path.

---
 rtl/ualink_dpmem_fifo_ctrl_pkg.sv | 17 +
 rtl/ualink_dpmem_fifo_ctrl_if.sv | 34 +++
 rtl/ualink_skid_buf2.sv | 56 +++++
 rtl/ualink_dpmem_fifo_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/ualink_dpmem_fifo_ctrl_pkg.sv
// rtl/ualink_dpmem_fifo_ctrl_pkg.sv - shared widths and wrap-bit pointer compares
package ualink_dpmem_fifo_ctrl_pkg;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int PTR_WIDTH      = DEF_ADDR_WIDTH + 1;

  function automatic logic ptr_empty(input logic [PTR_WIDTH-1:0] wr,
                                     input logic [PTR_WIDTH-1:0] rd);
    return wr == rd;
  endfunction

  function automatic logic ptr_full(input logic [PTR_WIDTH-1:0] wr,
                                    input logic [PTR_WIDTH-1:0] rd);
    return (wr[PTR_WIDTH-1] != rd[PTR_WIDTH-1]) &&
           (wr[PTR_WIDTH-2:0] == rd[PTR_WIDTH-2:0]);
  endfunction
endpackage

// File: rtl/ualink_dpmem_fifo_ctrl_if.sv
// rtl/ualink_dpmem_fifo_ctrl_if.sv - ingress/egress streams and dual-port RAM bus
interface ualink_dpmem_fifo_ctrl_if
  import ualink_dpmem_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  ram_we_a;
  logic [ADDR_WIDTH-1:0] ram_addr_a;
  logic [DATA_WIDTH-1:0] ram_din_a;
  logic                  ram_we_b;
  logic [ADDR_WIDTH-1:0] ram_addr_b;
  logic [DATA_WIDTH-1:0] ram_dout_b;

  modport master (
    input  s_valid, s_data, s_last, m_ready, ram_dout_b,
    output s_ready, m_valid, m_data, m_last,
    output ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, ram_dout_b,
    input  s_ready, m_valid, m_data, m_last,
    input  ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b
  );
endinterface

// File: rtl/ualink_skid_buf2.sv
// rtl/ualink_skid_buf2.sv - 2-entry in-order skid buffer absorbing RAM read latency
module ualink_skid_buf2 #(
  parameter int WIDTH = 65
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [1:0]       o_cnt
);
  logic [WIDTH-1:0] r_ent0;
  logic [WIDTH-1:0] r_ent1;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign o_rd_valid = (r_cnt != 2'd0);
  assign o_rd_data  = r_ent0;
  assign o_cnt      = r_cnt;
  assign w_pop      = o_rd_valid && i_rd_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= 2'd0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({i_wr_valid, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= i_wr_data;
          else               r_ent1 <= i_wr_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Count holds; new word lands behind whatever remains after the pop.
          if (r_cnt == 2'd1) begin
            r_ent0 <= i_wr_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_wr_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ualink_dpmem_fifo_ctrl.sv
// rtl/ualink_dpmem_fifo_ctrl.sv - circular packet buffer over an external dual-port RAM
module ualink_dpmem_fifo_ctrl
  import ualink_dpmem_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    i_axi_aclk,
  input  logic                    i_axi_resetn,
  input  logic                    i_flush,
  ualink_dpmem_fifo_ctrl_if.master bus,
  output logic [ADDR_WIDTH:0]     o_fill_level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DEPTH-1:0]      r_last_flag;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_m_valid;
  logic [1:0]            w_skid_cnt;
  logic [2:0]            w_occ;
  logic [DATA_WIDTH:0]   w_head;

  assign w_empty = ptr_empty(r_wr_ptr, r_rd_ptr);
  assign w_full  = ptr_full(r_wr_ptr, r_rd_ptr);

  // Reset gates the write side combinationally so nothing reaches the RAM while held.
  assign bus.s_ready    = i_axi_resetn && !w_full && !i_flush;
  assign w_push         = bus.s_valid && bus.s_ready;
  assign bus.ram_we_a   = w_push;
  assign bus.ram_addr_a = r_wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_din_a  = i_axi_resetn ? bus.s_data : '0;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_addr_b = r_rd_ptr[ADDR_WIDTH-1:0];

  assign w_pop   = w_m_valid && bus.m_ready;
  assign w_occ   = {1'b0, w_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = !w_empty && !i_flush && (w_occ < 3'd2);

  assign o_fill_level = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge i_axi_aclk or negedge i_axi_resetn) begin
    if (!i_axi_resetn) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_issue) begin
        r_rd_ptr        <= r_rd_ptr + PTR_ONE;
        r_inflight_last <= r_last_flag[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
      r_inflight <= w_issue;
    end
  end

  // Flags are only read for entries already written, so they need no reset.
  always_ff @(posedge i_axi_aclk) begin
    if (w_push) r_last_flag[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.s_last;
  end

  ualink_skid_buf2 #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .i_clk      (i_axi_aclk),
    .i_rst_n    (i_axi_resetn),
    .i_flush    (i_flush),
    .i_wr_valid (r_inflight),
    .i_wr_data  ({r_inflight_last, bus.ram_dout_b}),
    .i_rd_ready (bus.m_ready),
    .o_rd_valid (w_m_valid),
    .o_rd_data  (w_head),
    .o_cnt      (w_skid_cnt)
  );

  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = w_head[DATA_WIDTH-1:0];
  assign bus.m_last  = w_head[DATA_WIDTH];
endmodule
